// File: rtl/bpred_pkg.sv
// Purpose : shared types, counter encodings and saturating-counter helper for
//           the correlating branch predictor.
// Contents: ctr_t, CTR_* encodings, pht_state_e, ctr_sat_update().
package bpred_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  typedef enum logic {
    PHT_INIT  = 1'b0,
    PHT_READY = 1'b1
  } pht_state_e;

  // Two-bit saturating counter step toward the resolved outcome.
  function automatic ctr_t ctr_sat_update(input ctr_t ctr, input logic taken);
    ctr_t res;
    res = ctr;
    if (taken) begin
      if (ctr != CTR_ST) res = ctr_t'(ctr + 2'd1);
    end else begin
      if (ctr != CTR_SNT) res = ctr_t'(ctr - 2'd1);
    end
    return res;
  endfunction

endpackage

// File: rtl/bpred_pht.sv
// Purpose : pattern-history table storage with a post-reset init sweep.
//           Entries are addressed by {bank, index}. After reset every entry is
//           written with INIT_CTR, one per clock; ready rises the cycle after
//           the last entry is written and stays high until the next reset.
// Ports   : clk, rst (async, active-high)
//           ready                 - sweep complete
//           rd0_addr / rd0_data   - combinational read port 0
//           rd1_addr / rd1_data   - combinational read port 1
//           wr_en/wr_addr/wr_data - write port (honoured only when ready)
//           wr_old                - current contents at wr_addr (for RMW)
module bpred_pht
  import bpred_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 12,
  parameter ctr_t        INIT_CTR  = CTR_WNT
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ready,
  input  logic [ADDR_BITS-1:0] rd0_addr,
  output ctr_t                 rd0_data,
  input  logic [ADDR_BITS-1:0] rd1_addr,
  output ctr_t                 rd1_data,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  ctr_t                 wr_data,
  output ctr_t                 wr_old
);

  localparam int unsigned          NUM_ENTRIES = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_PTR    = '1;

  ctr_t                 r_mem [NUM_ENTRIES];
  pht_state_e           r_state;
  pht_state_e           w_state_nxt;
  logic [ADDR_BITS-1:0] r_ptr;
  logic [ADDR_BITS-1:0] w_ptr_nxt;
  logic                 r_ready;
  logic                 w_sweep_we;
  logic                 w_mem_we;
  logic [ADDR_BITS-1:0] w_mem_addr;
  ctr_t                 w_mem_data;

  // Sweep FSM: state, pointer and ready registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= PHT_INIT;
      r_ptr   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_ready <= (w_state_nxt == PHT_READY);
    end
  end

  // Sweep FSM: next state; the edge writing the last entry moves to READY.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sweep_we  = 1'b0;
    case (r_state)
      PHT_INIT: begin
        w_sweep_we = 1'b1;
        w_ptr_nxt  = ADDR_BITS'(r_ptr + 1'b1);
        if (r_ptr == LAST_PTR) w_state_nxt = PHT_READY;
      end
      PHT_READY: begin
        w_state_nxt = PHT_READY;
      end
      default: begin
        w_state_nxt = PHT_INIT;
      end
    endcase
  end

  // Write-port mux: the sweep owns the array until ready.
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = wr_addr;
    w_mem_data = wr_data;
    if (w_sweep_we) begin
      w_mem_we   = 1'b1;
      w_mem_addr = r_ptr;
      w_mem_data = INIT_CTR;
    end else if (wr_en && r_ready) begin
      w_mem_we = 1'b1;
    end
  end

  // Counter array; no reset, contents are defined by the sweep.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
  end

  assign rd0_data = r_mem[rd0_addr];
  assign rd1_data = r_mem[rd1_addr];
  assign wr_old   = r_mem[wr_addr];
  assign ready    = r_ready;

endmodule

// File: rtl/bpred_corr_table.sv
// Purpose : (m,2) correlating branch predictor. 2^HIST_BITS banks of
//           2^IDX_BITS two-bit counters, bank selected by the global history
//           register. Combinational lookups for fetch and ROB, clocked commit
//           training with saturating counters, GHR shifted on each update.
// Ports   : clk, rst (async, active-high)
//           ready                   - init sweep complete
//           pc_rd_addr/pc_predict   - fetch lookup, taken bit
//           rob_rd_addr/rob_predict - ROB lookup, full counter
//           upd_valid/upd_addr/upd_taken - commit training
//           ghr_out                 - global history, LSB newest
//           stat_updates/stat_mispredicts - present only with BPRED_STATS_EN
// Config  : `define BPRED_STATS_EN adds the statistics counters and ports.
module bpred_corr_table
  import bpred_pkg::*;
#(
  parameter int unsigned HIST_BITS = 2,
  parameter int unsigned IDX_BITS  = 10,
  parameter ctr_t        INIT_CTR  = 2'b01
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ready,
  input  logic [31:0]          pc_rd_addr,
  output logic                 pc_predict,
  input  logic [31:0]          rob_rd_addr,
  output logic [1:0]           rob_predict,
  input  logic                 upd_valid,
  input  logic [31:0]          upd_addr,
  input  logic                 upd_taken,
`ifdef BPRED_STATS_EN
  output logic [31:0]          stat_updates,
  output logic [31:0]          stat_mispredicts,
`endif
  output logic [HIST_BITS-1:0] ghr_out
);

  localparam int unsigned PHT_BITS = HIST_BITS + IDX_BITS;

  logic [HIST_BITS-1:0] r_ghr;
  logic [HIST_BITS-1:0] w_ghr_shift;
  logic                 w_ready;
  logic [PHT_BITS-1:0]  w_pc_idx;
  logic [PHT_BITS-1:0]  w_rob_idx;
  logic [PHT_BITS-1:0]  w_upd_idx;
  ctr_t                 w_pc_ctr;
  ctr_t                 w_rob_ctr;
  ctr_t                 w_upd_old;
  ctr_t                 w_upd_new;
  logic                 w_upd_accept;
  logic                 w_unused_addr;

  // Table index = {history, low address bits}; upper address bits ignored.
  assign w_pc_idx  = {r_ghr, pc_rd_addr[IDX_BITS-1:0]};
  assign w_rob_idx = {r_ghr, rob_rd_addr[IDX_BITS-1:0]};
  assign w_upd_idx = {r_ghr, upd_addr[IDX_BITS-1:0]};

  assign w_unused_addr = ^{pc_rd_addr[31:IDX_BITS], rob_rd_addr[31:IDX_BITS],
                           upd_addr[31:IDX_BITS]};

  bpred_pht #(
    .ADDR_BITS (PHT_BITS),
    .INIT_CTR  (INIT_CTR)
  ) u_pht (
    .clk      (clk),
    .rst      (rst),
    .ready    (w_ready),
    .rd0_addr (w_pc_idx),
    .rd0_data (w_pc_ctr),
    .rd1_addr (w_rob_idx),
    .rd1_data (w_rob_ctr),
    .wr_en    (w_upd_accept),
    .wr_addr  (w_upd_idx),
    .wr_data  (w_upd_new),
    .wr_old   (w_upd_old)
  );

  // Updates are dropped while the sweep is still running.
  assign w_upd_accept = upd_valid & w_ready;
  assign w_upd_new    = ctr_sat_update(w_upd_old, upd_taken);

  // History shift; single-bit history simply takes the latest outcome.
  generate
    if (HIST_BITS == 1) begin : g_ghr1
      assign w_ghr_shift = upd_taken;
    end else begin : g_ghrn
      assign w_ghr_shift = {r_ghr[HIST_BITS-2:0], upd_taken};
    end
  endgenerate

  // Global history register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ghr <= '0;
    end else if (w_upd_accept) begin
      r_ghr <= w_ghr_shift;
    end
  end

`ifdef BPRED_STATS_EN
  logic [31:0] r_stat_updates;
  logic [31:0] r_stat_mispredicts;

  // Update and mispredict counters; mispredict judged on the pre-update MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_updates     <= '0;
      r_stat_mispredicts <= '0;
    end else if (w_upd_accept) begin
      r_stat_updates <= 32'(r_stat_updates + 32'd1);
      if (w_upd_old[1] != upd_taken)
        r_stat_mispredicts <= 32'(r_stat_mispredicts + 32'd1);
    end
  end

  assign stat_updates     = r_stat_updates;
  assign stat_mispredicts = r_stat_mispredicts;
`endif

  // Lookups are masked to the init value until the sweep completes.
  assign pc_predict  = w_ready & w_pc_ctr[1];
  assign rob_predict = w_ready ? w_rob_ctr : INIT_CTR;
  assign ready       = w_ready;
  assign ghr_out     = r_ghr;

endmodule

// File: doc/bpred_corr_table.md
Name: bpred_corr_table

Overview:
- Parametrised (m,2) correlating branch predictor; successor to the fixed 2-bit-history, 1024-entry predictor.
- Holds 2^HIST_BITS pattern-history banks of 2^IDX_BITS two-bit saturating counters, selected by a global history register (GHR).
- Serves combinational reads to the fetch stage (PC) and to the ROB.
- Is trained by clocked commit updates carrying only the resolved outcome; counter arithmetic is internal.
- Clears itself after reset with a sweep state machine.

Parameters:
- HIST_BITS, 2, GHR width (>=1); number of banks = 2^HIST_BITS.
- IDX_BITS, 10, counters per bank = 2^IDX_BITS; index = addr[IDX_BITS-1:0], upper address bits ignored.
- INIT_CTR, 2'b01, counter value written by the reset sweep.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- ready  out  1  high once the init sweep has completed.
- pc_rd_addr  in  32  fetch lookup address.
- pc_predict  out  1  taken prediction, MSB of selected counter.
- rob_rd_addr  in  32  ROB lookup address.
- rob_predict  out  2  full selected counter.
- upd_valid  in  1  commit update strobe, one update per cycle.
- upd_addr  in  32  address of the resolved branch.
- upd_taken  in  1  resolved outcome.
- ghr_out  out  HIST_BITS  current GHR; LSB is the newest outcome.

Behaviour:
- Reset: the clock is one clock; reset is asynchronous and active-high (clk, rst).
- On rst assertion: GHR=0, sweep pointer=0, state=INIT, ready=0, statistics=0, all immediately.
- FSM INIT: each clk writes INIT_CTR to one entry (pointer over {bank, index}, 2^(HIST_BITS+IDX_BITS) entries) and increments the pointer.
- FSM INIT -> READY on the edge that writes the last entry; ready=1 from the next cycle. Default config: ready rises exactly 4096 cycles after rst deasserts.
- During INIT: pc_predict=0, rob_predict=INIT_CTR, upd_valid ignored, GHR does not shift.
- READY is terminal until the next rst.
- Reads are combinational: counter = bank[GHR][addr idx]. Both ports are independent and may hit the same entry.
- Update, on posedge in READY with upd_valid=1:
  - Selected entry = bank[GHR][upd_addr idx].
  - If taken: saturating increment, 11 stays 11. If not taken: saturating decrement, 00 stays 00.
  - Same edge: GHR <= {GHR[HIST_BITS-2:0], upd_taken}. For HIST_BITS=1: GHR <= upd_taken.
- Read and update in the same cycle: reads return the pre-update counter and use the old GHR. New values are visible the following cycle; no bypass.
- rst mid-operation: all training is discarded and the sweep restarts from entry 0.

Optional Feature:
- Macro BPRED_STATS_EN.
- Defined:
  - Adds outputs stat_updates[31:0] and stat_mispredicts[31:0], reset to 0, wrap modulo 2^32.
  - stat_updates increments per accepted update.
  - stat_mispredicts increments when the pre-update counter MSB != upd_taken.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package bpred_pkg:
  - Counter constants CTR_SNT=00, CTR_WNT=01, CTR_WT=10, CTR_ST=11.
  - Function ctr_sat_update(ctr, taken).
  - Typedef ctr_t (2 bits).
- Sub-module bpred_pht: counter storage, init-sweep FSM and ready. It exposes two read ports and one write port.
- The top level holds the GHR, index formation, update logic and statistics.

Test Plan:
- Reset/init: hold rst 3 cycles, then release. Required: ready=0 for 4096 cycles, then 1. Any address reads pc_predict=0, rob_predict=01, ghr_out=00.
- Saturation: 5 taken updates to 0x10.
  - Banks 0 and 1 go 01->10; bank 3 goes 01->10->11->11.
  - Then ghr_out=11, rob_predict(0x10)=11, pc_predict(0x10)=1.
- History separation: from the previous step, apply 1 not-taken update to 0x10.
  - Bank 3 entry becomes 10; ghr_out=10.
  - rob_predict(0x10)=01 (bank 2); rob_predict(0x410)=01 (upper bits ignored).
- Update during INIT: upd_valid=1, upd_taken=1 throughout the sweep. After ready: ghr_out=00 and every sampled entry=01.
- Reset mid-operation: train as in the saturation step, then assert rst asynchronously between edges.
  - ready=0 and ghr_out=00 without a clock edge.
  - After the sweep, rob_predict(0x10)=01.
- Stats (BPRED_STATS_EN): the saturation sequence from a fresh init gives stat_updates=5, stat_mispredicts=3.
